ex_alu_unit: RTL
================

EX_ALU_UNIT -- requirements
Module: ex_alu_unit

Interface
REQ-001 Parameter XLEN, default 32, data width; only 32 is supported.
REQ-002 Parameter SERIAL_SHIFT, default 1; 1 = shifts execute one bit per cycle, 0 = shifts complete in a single cycle.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  the EX-stage operation is valid this cycle.
REQ-006 alu_ctrl  input  4  operation code from the ALU control decoder.
REQ-007 op_a  input  XLEN  first operand (rs1 or PC).
REQ-008 op_b  input  XLEN  second operand (rs2 or immediate); for shifts only op_b[4:0] is the amount.
REQ-009 mem_stall  input  1  downstream stall; freezes the whole block.
REQ-010 flush  input  1  synchronous kill of the in-flight and incoming operation.
REQ-011 busy  output  1  stall request to upstream; upstream holds its instruction while high.
REQ-012 out_valid  output  1  result/zero registers hold a valid result.
REQ-013 result  output  XLEN  registered ALU result.
REQ-014 zero  output  1  registered (result == 0), updated together with result.

Function
REQ-015 Opcodes: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT (signed), 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASS (result = op_b); 1011-1111 execute as ADD.
REQ-016 Arithmetic wraps modulo 2^32; SLT/SLTU yield 0 or 1 zero-extended.
REQ-017 States: IDLE, SHIFT; busy = (state == SHIFT).
REQ-018 IDLE, in_valid=1, no flush, no mem_stall, non-shift op (or SERIAL_SHIFT=0): result, zero and out_valid=1 are registered at that edge (1-cycle latency); state stays IDLE.
REQ-019 IDLE, accepted shift with SERIAL_SHIFT=1 and amount 0: result = op_a, out_valid=1 at that edge; state stays IDLE.
REQ-020 IDLE, accepted shift with amount n in 1..31: op_a, op, and count=n are latched; state goes to SHIFT; out_valid=0 at that edge.
REQ-021 SHIFT: each unstalled cycle shifts by one bit (SRA replicates bit 31) and decrements count; the edge at which count reaches 0 writes result/zero with out_valid=1 and returns to IDLE; total latency n cycles after acceptance.
REQ-022 in_valid is ignored while in SHIFT.
REQ-023 An IDLE cycle with no accepted operation sets out_valid=0 at the edge; result and zero hold their values.
REQ-024 mem_stall=1 without flush: state, count, result, zero and out_valid all hold; no input accepted.
REQ-025 flush=1 (priority over mem_stall and in_valid): out_valid=0, state=IDLE, count=0, incoming operation dropped; result and zero hold.
REQ-026 A flush in the final SHIFT cycle discards that result (out_valid=0).

Reset
REQ-027 rst_n low asynchronously sets state=IDLE, count=0, result=0, zero=0, out_valid=0, busy=0, regardless of any operation in flight.
REQ-028 The first edge after rst_n deasserts may accept an operation.

Structure
REQ-029 Package alu_pkg holds the ALU_* opcode constants (shared with the ALU control decoder), XLEN, and the state enum.
REQ-030 Sub-module serial_shifter holds the shift data register, the 5-bit count and the one-bit-per-step logic; ex_alu_unit holds the FSM, the remaining ALU ops and the output registers.

Verification
REQ-031 ADD 0x7FFFFFFF+1 -> result 0x80000000, zero 0, out_valid one cycle after accept; SUB 5-5 -> result 0, zero 1.
REQ-032 SLT 0xFFFFFFFF vs 1 -> 1; SLTU with the same operands -> 0; PASS op_b=0x12345000 -> 0x12345000.
REQ-033 SRA 0x80000000 by 4, SERIAL_SHIFT=1 -> busy high 4 cycles, result 0xF8000000 with out_valid 4 cycles after accept; amount 0 -> result op_a after 1 cycle, busy never high.
REQ-034 SLL 1 by 31 with mem_stall high for 3 cycles mid-shift -> result 0x80000000 at 34 cycles; busy stays high throughout the stall.
REQ-035 Flush on the second SHIFT cycle -> out_valid stays 0, busy drops the next cycle, the next ADD completes normally.
REQ-036 rst_n asserted mid-SHIFT -> all outputs 0 immediately (asynchronously); the next accepted operation is unaffected.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings used by the ALU control decoder
// and the EX-stage ALU, the datapath width and the EX-stage FSM states.
package alu_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLL  = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_SLTU = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b1000;
   localparam logic [3:0] ALU_AND  = 4'b1001;
   localparam logic [3:0] ALU_PASS = 4'b1010;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } alu_state_e;

   // True for the three shift opcodes.
   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/serial_shifter.sv
// One-bit-per-step shifter: latches the operand, opcode and amount, then
// moves the data one position per step while counting the amount down.
module serial_shifter
   import alu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         step_i,
   input  logic         clear_i,
   input  logic [3:0]   op_i,
   input  logic [W-1:0] data_i,
   input  logic [4:0]   amt_i,
   output logic [W-1:0] step_data_o,
   output logic [4:0]   count_o
);

   logic [W-1:0] data_q;
   logic [3:0]   op_q;
   logic [4:0]   count_q;
   logic [4:0]   count_d;

   // Value the data register takes after one more step; also the final
   // result when the count is about to reach zero.
   always_comb begin
      step_data_o = {1'b0, data_q[W-1:1]};
      case (op_q)
         ALU_SLL: step_data_o = {data_q[W-2:0], 1'b0};
         ALU_SRA: step_data_o = {data_q[W-1], data_q[W-1:1]};
         default: step_data_o = {1'b0, data_q[W-1:1]};
      endcase
   end

   // Remaining-step counter: flush clears, load sets, each step decrements.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = 5'd0;
      end else if (load_i) begin
         count_d = amt_i;
      end else if (step_i) begin
         count_d = count_q - 5'd1;
      end
   end

   // Counter register is control state and is cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 5'd0;
      end else begin
         count_q <= count_d;
      end
   end

   // Shift data and opcode registers; contents are only meaningful while
   // the counter is non-zero, so they need no reset.
   always_ff @(posedge clk) begin
      if (load_i) begin
         data_q <= data_i;
         op_q   <= op_i;
      end else if (step_i) begin
         data_q <= step_data_o;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/ex_alu_unit.sv
// EX-stage ALU: single-cycle ops plus shifts that either complete in one
// cycle (barrel) or run one bit per cycle, stalling upstream via busy.
module ex_alu_unit
   import alu_pkg::*;
#(
   parameter int XLEN         = alu_pkg::XLEN,
   parameter bit SERIAL_SHIFT = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            mem_stall,
   input  logic            flush,
   output logic            busy,
   output logic            out_valid,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   alu_state_e      state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            zero_q, zero_d;
   logic            out_valid_q, out_valid_d;

   logic [XLEN-1:0] alu_res;
   logic [4:0]      shamt;
   logic            sh_load, sh_step, sh_clear;
   logic [XLEN-1:0] sh_step_data;
   logic [4:0]      sh_count;

   assign shamt = op_b[4:0];

   // Single-cycle ALU result. In serial mode a shift only reaches this path
   // with amount 0, where the answer is op_a unchanged.
   always_comb begin
      alu_res = op_a + op_b;
      case (alu_ctrl)
         ALU_SUB:  alu_res = op_a - op_b;
         ALU_SLL:  alu_res = SERIAL_SHIFT ? op_a : (op_a << shamt);
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         ALU_XOR:  alu_res = op_a ^ op_b;
         ALU_SRL:  alu_res = SERIAL_SHIFT ? op_a : (op_a >> shamt);
         ALU_SRA:  alu_res = SERIAL_SHIFT ? op_a : ($signed(op_a) >>> shamt);
         ALU_OR:   alu_res = op_a | op_b;
         ALU_AND:  alu_res = op_a & op_b;
         ALU_PASS: alu_res = op_b;
         default:  alu_res = op_a + op_b;
      endcase
   end

   serial_shifter #(
      .W (XLEN)
   ) u_shifter (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (sh_load),
      .step_i      (sh_step),
      .clear_i     (sh_clear),
      .op_i        (alu_ctrl),
      .data_i      (op_a),
      .amt_i       (shamt),
      .step_data_o (sh_step_data),
      .count_o     (sh_count)
   );

   // Next-state and output-register logic. Flush beats stall, stall
   // freezes everything, otherwise IDLE accepts and SHIFT steps.
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      zero_d      = zero_q;
      out_valid_d = out_valid_q;
      sh_load     = 1'b0;
      sh_step     = 1'b0;
      sh_clear    = 1'b0;
      if (flush) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         sh_clear    = 1'b1;
      end else if (!mem_stall) begin
         case (state_q)
            IDLE: begin
               out_valid_d = 1'b0;
               if (in_valid) begin
                  if (SERIAL_SHIFT && is_shift_op(alu_ctrl) && (shamt != 5'd0)) begin
                     sh_load = 1'b1;
                     state_d = SHIFT;
                  end else begin
                     result_d    = alu_res;
                     zero_d      = (alu_res == '0);
                     out_valid_d = 1'b1;
                  end
               end
            end
            SHIFT: begin
               sh_step     = 1'b1;
               out_valid_d = 1'b0;
               if (sh_count == 5'd1) begin
                  result_d    = sh_step_data;
                  zero_d      = (sh_step_data == '0);
                  out_valid_d = 1'b1;
                  state_d     = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         result_q    <= '0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign busy      = (state_q == SHIFT);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;

endmodule
